// File: rtl/window_mac.sv
// window_mac: KxK sliding-window signed MAC over a column stream.
// Ports: clk, rst (async, active-high); weight_wen/weight_din load the
//   weights in raster order; col_valid/col_din deliver one column per
//   cycle; dout/dout_valid/dout_last carry results; weights_ready is
//   high once a full weight set is loaded.
// Option: define WINDOW_MAC_RELU_EN to clamp negative results to 0.
module window_mac #(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LENGTH  = 32,
    parameter int KERNEL_LENGTH = 3,
    parameter int OUT_WIDTH     = 2*DATA_WIDTH
                                + $clog2(KERNEL_LENGTH*KERNEL_LENGTH)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    weight_wen,
    input  logic [DATA_WIDTH-1:0]                   weight_din,
    input  logic                                    col_valid,
    input  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] col_din,
    output logic signed [OUT_WIDTH-1:0]             dout,
    output logic                                    dout_valid,
    output logic                                    dout_last,
    output logic                                    weights_ready
);
    localparam int KK = KERNEL_LENGTH*KERNEL_LENGTH;
    localparam int PW = 2*DATA_WIDTH;
    localparam int IW = (KK > 1) ? $clog2(KK) : 1;
    localparam int CW = $clog2(BURST_LENGTH+1);

    localparam logic [IW-1:0] W_LAST = IW'(KK-1);
    localparam logic [CW-1:0] C_FILL = CW'(KERNEL_LENGTH-1);
    localparam logic [CW-1:0] C_LAST = CW'(BURST_LENGTH-1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

    state_t                     state;
    logic [IW-1:0]              w_idx;
    logic [CW-1:0]              col_cnt;
    logic [DATA_WIDTH-1:0]      weight [KK];
    logic [DATA_WIDTH-1:0]      win [KERNEL_LENGTH][KERNEL_LENGTH];
    logic                       win_valid;
    logic                       win_last;
    logic signed [PW-1:0]       prod [KK];
    logic                       p_valid;
    logic                       p_last;
    logic signed [OUT_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] result;
    logic                       active;
    logic                       flush;
    logic                       shift;

    function automatic logic signed [PW-1:0] sext(
        input logic [DATA_WIDTH-1:0] v
    );
        return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    endfunction

    assign active = (state == FILL) || (state == RUN);
    // A weight write while streaming restarts the load and kills the row.
    assign flush  = active && weight_wen;
    assign shift  = active && col_valid && !weight_wen;

    // Weight store; outside LOAD a write always targets entry 0.
    always_ff @(posedge clk) begin
        if (weight_wen)
            weight[(state == LOAD) ? w_idx : '0] <= weight_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            w_idx         <= '0;
            col_cnt       <= '0;
            weights_ready <= 1'b0;
            win_valid     <= 1'b0;
            win_last      <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (weight_wen) begin
                        w_idx <= IW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (weight_wen) begin
                        if (w_idx == W_LAST) begin
                            w_idx         <= '0;
                            weights_ready <= 1'b1;
                            col_cnt       <= '0;
                            state         <= FILL;
                        end else begin
                            w_idx <= w_idx + 1'b1;
                        end
                    end
                end
                FILL, RUN: begin
                    if (weight_wen) begin
                        w_idx         <= IW'(1);
                        weights_ready <= 1'b0;
                        col_cnt       <= '0;
                        state         <= LOAD;
                    end else if (col_valid) begin
                        if (state == FILL) begin
                            col_cnt <= col_cnt + 1'b1;
                            if (col_cnt == C_FILL) begin
                                win_valid <= 1'b1;
                                state     <= RUN;
                            end
                        end else begin
                            win_valid <= 1'b1;
                            if (col_cnt == C_LAST) begin
                                win_last <= 1'b1;
                                col_cnt  <= '0;
                                state    <= FILL;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window: column KERNEL_LENGTH-1 is the newest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < KERNEL_LENGTH; r++)
                for (int c = 0; c < KERNEL_LENGTH; c++)
                    win[r][c] <= '0;
        end else if (flush) begin
            for (int r = 0; r < KERNEL_LENGTH; r++)
                for (int c = 0; c < KERNEL_LENGTH; c++)
                    win[r][c] <= '0;
        end else if (shift) begin
            for (int r = 0; r < KERNEL_LENGTH; r++) begin
                for (int c = 0; c < KERNEL_LENGTH-1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][KERNEL_LENGTH-1] <= col_din[r];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < KK; i++)
            sum = sum + {{(OUT_WIDTH-PW){prod[i][PW-1]}}, prod[i]};
    end

`ifdef WINDOW_MAC_RELU_EN
    assign result = sum[OUT_WIDTH-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KK; i++)
                prod[i] <= '0;
            p_valid    <= 1'b0;
            p_last     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            for (int r = 0; r < KERNEL_LENGTH; r++)
                for (int c = 0; c < KERNEL_LENGTH; c++)
                    prod[r*KERNEL_LENGTH+c] <=
                        sext(win[r][c]) * sext(weight[r*KERNEL_LENGTH+c]);
            p_valid    <= win_valid && !flush;
            p_last     <= win_last && !flush;
            dout_valid <= p_valid && !flush;
            dout_last  <= p_last && !flush;
            if (p_valid && !flush)
                dout <= result;
        end
    end
endmodule

// File: tb/tb_window_mac.sv
// tb_window_mac: scenario table plus random stream for window_mac,
//   checked cycle by cycle against a queue-based reference model.
module tb_window_mac;
    localparam int DW = 32;
    localparam int BL = 32;
    localparam int K  = 3;
    localparam int KK = K*K;
    localparam int OW = 2*DW + $clog2(KK);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   weight_wen = 1'b0;
    logic [DW-1:0]          weight_din = '0;
    logic                   col_valid = 1'b0;
    logic [K-1:0][DW-1:0]   col_din = '0;
    logic signed [OW-1:0]   dout;
    logic                   dout_valid;
    logic                   dout_last;
    logic                   weights_ready;

    always #5 clk = ~clk;

    window_mac dut (
        .clk           (clk),
        .rst           (rst),
        .weight_wen    (weight_wen),
        .weight_din    (weight_din),
        .col_valid     (col_valid),
        .col_din       (col_din),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_last     (dout_last),
        .weights_ready (weights_ready)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int                   cyc;
        logic signed [OW-1:0] val;
        bit                   last;
    } exp_t;

    exp_t q[$];
    logic signed [OW-1:0] m_w [KK];
    logic signed [OW-1:0] m_hist [BL][K];
    int m_idx = 0;
    bit m_ready = 0;
    int m_cnt = 0;

    int cap_n;
    int cap_nlast;
    bit cap_final_last;
    logic signed [OW-1:0] cap_first;
    logic signed [OW-1:0] cap_lastv;

    task automatic chk(input string n, input logic signed [OW-1:0] got,
                       input logic signed [OW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     n, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_idx = 0;
        m_ready = 0;
        m_cnt = 0;
    endtask

    // Reference: a row is the list of accepted columns; each result is
    // the dot product of the last K columns with the weights.
    task automatic model_edge();
        logic signed [OW-1:0] acc;
        if (rst) return;
        if (weight_wen) begin
            if (m_ready) begin
                while (q.size() > 0 && q[q.size()-1].cyc >= cyc)
                    void'(q.pop_back());
                m_ready = 0;
                m_idx = 0;
            end
            m_w[m_idx] = $signed(weight_din);
            m_idx++;
            if (m_idx == KK) begin
                m_ready = 1;
                m_idx = 0;
                m_cnt = 0;
            end
        end else if (col_valid && m_ready) begin
            for (int r = 0; r < K; r++)
                m_hist[m_cnt][r] = $signed(col_din[r]);
            m_cnt++;
            if (m_cnt >= K) begin
                acc = '0;
                for (int j = 0; j < K; j++)
                    for (int r = 0; r < K; r++)
                        acc += m_hist[m_cnt-K+j][r] * m_w[r*K+j];
`ifdef WINDOW_MAC_RELU_EN
                if (acc < 0) acc = '0;
`endif
                q.push_back('{cyc + 2, acc, m_cnt == BL});
                if (m_cnt == BL) m_cnt = 0;
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("dout_valid", dout_valid, 1);
            chk("dout", dout, e.val);
            chk("dout_last", dout_last, e.last);
        end else begin
            chk("idle_valid", dout_valid, 0);
        end
        chk("weights_ready", weights_ready, m_ready);
        if (dout_valid) begin
            cap_n++;
            if (cap_n == 1) cap_first = dout;
            cap_lastv = dout;
            cap_final_last = dout_last;
            if (dout_last) cap_nlast++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic cap_clear();
        cap_n = 0;
        cap_nlast = 0;
        cap_final_last = 0;
        cap_first = '0;
        cap_lastv = '0;
    endtask

    task automatic idle(input int n);
        weight_wen = 0;
        col_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        weight_wen = 0;
        col_valid = 0;
        rst = 1;
        #1;
        model_reset();
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_ready", weights_ready, 0);
        tick();
        rst = 0;
    endtask

    function automatic int wval(input int wsel, input int i);
        case (wsel)
            0: return 1;
            1: return (i == 4) ? 1 : 0;
            2: return -1;
            default: return 2;
        endcase
    endfunction

    task automatic load_w(input int wsel, input int from);
        for (int i = from; i < KK; i++) begin
            weight_wen = 1;
            weight_din = wval(wsel, i);
            tick();
        end
        weight_wen = 0;
    endtask

    task automatic send_col(input int n, input int cmode);
        col_valid = 1;
        for (int r = 0; r < K; r++)
            col_din[r] = (cmode == 1) ? 100*r + n : n;
        tick();
        col_valid = 0;
    endtask

    typedef struct {
        string                name;
        int                   wsel;
        int                   cmode;
        int                   gap_len;
        int                   rows;
        int                   exp_n;
        logic signed [OW-1:0] exp_first;
        logic signed [OW-1:0] exp_last;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{"ones", 0, 0, 0, 1, 30, 18, 279};
        tbl[1] = '{"ones_gap", 0, 0, 5, 2, 60, 18, 279};
        tbl[2] = '{"center", 1, 1, 0, 1, 30, 102, 131};
`ifdef WINDOW_MAC_RELU_EN
        tbl[3] = '{"neg_relu", 2, 0, 0, 1, 30, 0, 0};
`else
        tbl[3] = '{"neg", 2, 0, 0, 1, 30, -18, -279};
`endif

        for (int t = 0; t < 4; t++) begin
            do_reset();
            load_w(tbl[t].wsel, 0);
            cap_clear();
            for (int row = 0; row < tbl[t].rows; row++) begin
                for (int n = 1; n <= BL; n++) begin
                    send_col(n, tbl[t].cmode);
                    if (row == 0 && n == 10) idle(tbl[t].gap_len);
                end
            end
            idle(4);
            chk({tbl[t].name, "_count"}, cap_n, tbl[t].exp_n);
            chk({tbl[t].name, "_first"}, cap_first, tbl[t].exp_first);
            chk({tbl[t].name, "_lastv"}, cap_lastv, tbl[t].exp_last);
            chk({tbl[t].name, "_nlast"}, cap_nlast, tbl[t].rows);
            chk({tbl[t].name, "_final_last"}, cap_final_last, 1);
        end

        // Asynchronous reset mid-row, then columns ignored until reload.
        do_reset();
        load_w(0, 0);
        for (int n = 1; n <= 15; n++) send_col(n, 0);
        rst = 1;
        #1;
        model_reset();
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_ready", weights_ready, 0);
        tick();
        rst = 0;
        cap_clear();
        for (int n = 16; n <= 20; n++) send_col(n, 0);
        idle(3);
        chk("midrst_ignored", cap_n, 0);
        load_w(0, 0);
        for (int n = 1; n <= BL; n++) send_col(n, 0);
        idle(4);
        chk("midrst_count", cap_n, 30);
        chk("midrst_first", cap_first, 18);

        // Weight write colliding with a column in RUN.
        do_reset();
        load_w(0, 0);
        for (int n = 1; n <= 10; n++) send_col(n, 0);
        cap_clear();
        weight_wen = 1;
        weight_din = 2;
        col_valid = 1;
        for (int r = 0; r < K; r++) col_din[r] = 11;
        tick();
        col_valid = 0;
        chk("restart_ready", weights_ready, 0);
        load_w(3, 1);
        idle(3);
        chk("restart_flushed", cap_n, 0);
        for (int n = 1; n <= BL; n++) send_col(n, 0);
        idle(4);
        chk("restart_count", cap_n, 30);
        chk("restart_first", cap_first, 36);

        // Random stream with occasional reloads.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (!m_ready)
                weight_wen = ($urandom_range(0, 1) == 0);
            else
                weight_wen = ($urandom_range(0, 299) == 0);
            weight_din = $urandom;
            col_valid = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < K; r++) col_din[r] = $urandom;
            tick();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/window_mac.md
Name: window_mac

Overview:
- Downstream consumer of the row-buffer splitter.
- Takes one KERNEL_LENGTH-row column vector per handshake and builds a KERNEL_LENGTH x KERNEL_LENGTH sliding window over each BURST_LENGTH-column row.
- Multiplies the window against a locally loaded signed weight set and emits one convolution result per complete window.
- Sits between the splitter output and the result DMA write path.

Parameters:
- DATA_WIDTH, 32, width of each pixel and weight (signed two's complement)
- BURST_LENGTH, 32, columns per row; window fill restarts at every row boundary
- KERNEL_LENGTH, 3, window edge; window size = KERNEL_LENGTH*KERNEL_LENGTH
- OUT_WIDTH, 2*DATA_WIDTH+$clog2(KERNEL_LENGTH*KERNEL_LENGTH), result width (68 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- weight_wen  in  1  write one weight this cycle
- weight_din  in  DATA_WIDTH  weight value, raster order (index r*KERNEL_LENGTH+c)
- col_valid  in  1  col_din holds a valid column this cycle
- col_din  in  [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]  column; element 0 = top row
- dout  out  OUT_WIDTH  signed convolution result
- dout_valid  out  1  dout valid (single-cycle pulse per result)
- dout_last  out  1  asserted with dout_valid on the final result of a row
- weights_ready  out  1  full weight set loaded

Behaviour:
- Reset (async, rst=1): state IDLE; dout=0, dout_valid=0, dout_last=0, weights_ready=0; weight index, column counter, window registers and pipeline valids cleared. Weight RAM contents are don't-care.
- States: IDLE, LOAD, FILL, RUN.
- IDLE: weight_wen -> store weight[0], index=1, go LOAD. col_valid ignored.
- LOAD: each weight_wen stores weight[index] and increments index. Storing index KERNEL_LENGTH*KERNEL_LENGTH-1 -> weights_ready=1, col counter=0, go FILL. col_valid ignored.
- FILL: each col_valid shifts col_din into the window (newest at column KERNEL_LENGTH-1, oldest column dropped) and increments the col counter. On the KERNEL_LENGTH-th column -> issue window, go RUN.
- RUN: each col_valid shifts and issues a window. When the column with counter = BURST_LENGTH-1 is accepted: issue that window with last=1, reset col counter to 0, go FILL. Windows never span two rows.
- col_valid=0 in FILL/RUN: window and counter hold; no gaps are inserted into the results.
- weight_wen in FILL/RUN: restart weight load. Store weight[0], index=1, weights_ready=0, flush window, counter and pipeline valids, go LOAD. If col_valid is asserted in the same cycle, weight_wen wins and the column is dropped.
- Arithmetic: result = sum over r,c of window[r][c]*weight[r*KERNEL_LENGTH+c]. Signed, full precision, sign-extended to OUT_WIDTH. No overflow possible.
- Pipeline:
  - stage 1 registers the KERNEL_LENGTH*KERNEL_LENGTH products;
  - stage 2 registers the adder-tree sum into dout.
  - Latency: a window issued by col_valid at edge t gives dout_valid at edge t+2. One result per cycle sustained.
- dout holds its last value when dout_valid=0.
- Results per row: BURST_LENGTH-KERNEL_LENGTH+1 (30 at defaults).

Optional Feature:
- Macro: WINDOW_MAC_RELU_EN.
- Defined: the stage-2 result is clamped to 0 when negative, before registering into dout. Latency is unchanged.
- Undefined: dout carries the raw signed sum.

Test Plan:
- Reset, load 9 weights = 1, then stream 32 columns with col n = (n,n,n), n=1..32, back-to-back -> 30 dout_valid pulses. First pulse 2 cycles after the col-3 handshake with dout=18, then 27, 36, ..., final dout=279 with dout_last=1.
- Same stream with col_valid dropped for 5 cycles after col 10 -> identical 30-value sequence, with a 5-cycle gap in dout_valid. Then a second row of 32 columns -> first new result only after its 3rd column (no cross-row window).
- Weights all 0 except weight[4]=1; columns (n, 100+n, 200+n) -> dout = 100+n-1 for each window ending at column n, n=3..32.
- All weights = -1 with col n = (n,n,n) -> without macro, first dout = -18. With WINDOW_MAC_RELU_EN, every dout = 0.
- Assert rst for 1 cycle mid-row after col 15 -> outputs 0 immediately, weights_ready=0. Columns are ignored until 9 weights are reloaded; the row then restarts from column count 0.
- Issue weight_wen with col_valid in RUN -> column dropped, state LOAD, weights_ready=0. In-flight stage-1/2 results are flushed (no dout_valid). After 9 weights, FILL resumes.
